// File: rtl/l1_ahb_mtx_in_stage.sv
// Master-port input stage of the L1 AHB matrix: forwards the address phase to the
// decoder, holding it and stalling the master while the target is not active.
// Optional address user bits are carried when L1AHBMTX_IN_STAGE_AUSER_EN is defined.
module l1_ahb_mtx_in_stage #(
  parameter int unsigned DEC_LSB = 10
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSELM,
  input  logic [31:0]          HADDRM,
  input  logic [1:0]           HTRANSM,
  input  logic                 HWRITEM,
  input  logic [2:0]           HSIZEM,
  input  logic [2:0]           HBURSTM,
  input  logic [3:0]           HPROTM,
  input  logic                 HMASTLOCKM,
  input  logic [31:0]          HAUSERM,
  input  logic                 HREADYM,
  output logic                 HREADYOUTM,
  output logic [1:0]           HRESPM,
  output logic                 sel_dec,
  output logic [31:0]          addr_dec,
  output logic [31-DEC_LSB:0]  decode_addr_dec,
  output logic [1:0]           trans_dec,
  output logic                 write_dec,
  output logic [2:0]           size_dec,
  output logic [2:0]           burst_dec,
  output logic [3:0]           prot_dec,
  output logic                 lock_dec,
  output logic [31:0]          auser_dec,
  output logic                 hready_dec,
  input  logic                 active_dec,
  input  logic                 readyout_dec,
  input  logic [1:0]           resp_dec
);

  logic        pend;
  logic [31:0] h_addr;
  logic [1:0]  h_trans;
  logic        h_write;
  logic [2:0]  h_size;
  logic [2:0]  h_burst;
  logic [3:0]  h_prot;
  logic        h_lock;

  logic live_valid;
  logic load;
  logic rel;

  assign live_valid = HSELM & HTRANSM[1] & HREADYM;
  assign load       = ~pend & live_valid & ~active_dec;
  assign rel        = pend & active_dec & readyout_dec;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend    <= 1'b0;
      h_addr  <= '0;
      h_trans <= '0;
      h_write <= 1'b0;
      h_size  <= '0;
      h_burst <= '0;
      h_prot  <= '0;
      h_lock  <= 1'b0;
    end else if (load) begin
      pend    <= 1'b1;
      h_addr  <= HADDRM;
      h_trans <= HTRANSM;
      h_write <= HWRITEM;
      h_size  <= HSIZEM;
      h_burst <= HBURSTM;
      h_prot  <= HPROTM;
      h_lock  <= HMASTLOCKM;
    end else if (rel) begin
      pend    <= 1'b0;
    end
  end

`ifdef L1AHBMTX_IN_STAGE_AUSER_EN
  logic [31:0] h_auser;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      h_auser <= '0;
    end else if (load) begin
      h_auser <= HAUSERM;
    end
  end

  assign auser_dec = pend ? h_auser : HAUSERM;
`else
  logic unused_auser;

  assign unused_auser = ^HAUSERM;
  assign auser_dec    = '0;
`endif

  always_comb begin
    sel_dec    = HSELM;
    addr_dec   = HADDRM;
    trans_dec  = HSELM ? HTRANSM : 2'b00;
    write_dec  = HWRITEM;
    size_dec   = HSIZEM;
    burst_dec  = HBURSTM;
    prot_dec   = HPROTM;
    lock_dec   = HMASTLOCKM;
    hready_dec = HREADYM;
    HREADYOUTM = readyout_dec;
    HRESPM     = resp_dec;
    // While holding, the decoder sees the held phase and the master is stalled;
    // any pending response is deferred until release.
    if (pend) begin
      sel_dec    = 1'b1;
      addr_dec   = h_addr;
      trans_dec  = h_trans;
      write_dec  = h_write;
      size_dec   = h_size;
      burst_dec  = h_burst;
      prot_dec   = h_prot;
      lock_dec   = h_lock;
      hready_dec = readyout_dec;
      HREADYOUTM = 1'b0;
      HRESPM     = 2'b00;
    end
  end

  assign decode_addr_dec = addr_dec[31:DEC_LSB];

endmodule

// File: tb/tb_l1_ahb_mtx_in_stage.sv
// Scoreboard bench for l1_ahb_mtx_in_stage: directed scenarios plus random traffic
// checked against a transaction-level model of the holding behaviour.
module tb_l1_ahb_mtx_in_stage;

  localparam int unsigned DEC_LSB = 10;

  logic                HCLK;
  logic                HRESET;
  logic                HSELM;
  logic [31:0]         HADDRM;
  logic [1:0]          HTRANSM;
  logic                HWRITEM;
  logic [2:0]          HSIZEM;
  logic [2:0]          HBURSTM;
  logic [3:0]          HPROTM;
  logic                HMASTLOCKM;
  logic [31:0]         HAUSERM;
  logic                HREADYM;
  logic                HREADYOUTM;
  logic [1:0]          HRESPM;
  logic                sel_dec;
  logic [31:0]         addr_dec;
  logic [31-DEC_LSB:0] decode_addr_dec;
  logic [1:0]          trans_dec;
  logic                write_dec;
  logic [2:0]          size_dec;
  logic [2:0]          burst_dec;
  logic [3:0]          prot_dec;
  logic                lock_dec;
  logic [31:0]         auser_dec;
  logic                hready_dec;
  logic                active_dec;
  logic                readyout_dec;
  logic [1:0]          resp_dec;

  l1_ahb_mtx_in_stage #(.DEC_LSB(DEC_LSB)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM),
    .HWRITEM(HWRITEM), .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM),
    .HMASTLOCKM(HMASTLOCKM), .HAUSERM(HAUSERM), .HREADYM(HREADYM),
    .HREADYOUTM(HREADYOUTM), .HRESPM(HRESPM), .sel_dec(sel_dec), .addr_dec(addr_dec),
    .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec), .write_dec(write_dec),
    .size_dec(size_dec), .burst_dec(burst_dec), .prot_dec(prot_dec), .lock_dec(lock_dec),
    .auser_dec(auser_dec), .hready_dec(hready_dec), .active_dec(active_dec),
    .readyout_dec(readyout_dec), .resp_dec(resp_dec)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
    logic [31:0] auser;
  } txn_t;

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic [31:0] daddr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
    logic [31:0] auser;
    logic        hready;
    logic        hreadyout;
    logic [1:0]  resp;
    logic        pend;
  } exp_t;

  txn_t held[$];   // at most one address phase parked in the stage
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] visible_auser(input logic [31:0] v);
`ifdef L1AHBMTX_IN_STAGE_AUSER_EN
    return v;
`else
    return 32'h0;
`endif
  endfunction

  // Record the response expected for the current inputs, then advance the model
  // across the coming clock edge.
  task automatic step();
    exp_t e;
    txn_t t;
    if (held.size() != 0) begin
      t = held[0];
      e.sel = 1'b1; e.addr = t.addr; e.trans = t.trans; e.write = t.write;
      e.size = t.size; e.burst = t.burst; e.prot = t.prot; e.lock = t.lock;
      e.auser = visible_auser(t.auser);
      e.hready = readyout_dec; e.hreadyout = 1'b0; e.resp = 2'b00; e.pend = 1'b1;
    end else begin
      e.sel = HSELM; e.addr = HADDRM; e.trans = HSELM ? HTRANSM : 2'b00;
      e.write = HWRITEM; e.size = HSIZEM; e.burst = HBURSTM; e.prot = HPROTM;
      e.lock = HMASTLOCKM; e.auser = visible_auser(HAUSERM);
      e.hready = HREADYM; e.hreadyout = readyout_dec; e.resp = resp_dec; e.pend = 1'b0;
    end
    e.daddr = e.addr >> DEC_LSB;
    exp_q.push_back(e);

    if (HRESET) begin
      held.delete();
    end else if (held.size() != 0) begin
      if (active_dec && readyout_dec) void'(held.pop_front());
    end else if (HSELM && HTRANSM[1] && HREADYM && !active_dec) begin
      t.addr = HADDRM; t.trans = HTRANSM; t.write = HWRITEM; t.size = HSIZEM;
      t.burst = HBURSTM; t.prot = HPROTM; t.lock = HMASTLOCKM; t.auser = HAUSERM;
      held.push_back(t);
    end
    @(posedge HCLK);
    #1;
  endtask

  always @(negedge HCLK) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("sel_dec", {31'b0, sel_dec}, {31'b0, e.sel});
      check("addr_dec", addr_dec, e.addr);
      check("decode_addr_dec", {{DEC_LSB{1'b0}}, decode_addr_dec}, e.daddr);
      check("trans_dec", {30'b0, trans_dec}, {30'b0, e.trans});
      check("ctrl_dec", {19'b0, write_dec, size_dec, burst_dec, prot_dec, lock_dec},
            {19'b0, e.write, e.size, e.burst, e.prot, e.lock});
      check("auser_dec", auser_dec, e.auser);
      check("hready_dec", {31'b0, hready_dec}, {31'b0, e.hready});
      check("HREADYOUTM", {31'b0, HREADYOUTM}, {31'b0, e.hreadyout});
      check("HRESPM", {30'b0, HRESPM}, {30'b0, e.resp});
      check("pend", {31'b0, dut.pend}, {31'b0, e.pend});
    end
  end

  task automatic idle_inputs();
    HSELM = 1'b0; HADDRM = '0; HTRANSM = 2'b00; HWRITEM = 1'b0; HSIZEM = 3'd2;
    HBURSTM = 3'd0; HPROTM = 4'h3; HMASTLOCKM = 1'b0; HAUSERM = '0; HREADYM = 1'b1;
    active_dec = 1'b1; readyout_dec = 1'b1; resp_dec = 2'b00;
  endtask

  task automatic nonseq(input logic [31:0] a, input logic act);
    HSELM = 1'b1; HADDRM = a; HTRANSM = 2'b10; HREADYM = 1'b1; active_dec = act;
    readyout_dec = 1'b1;
  endtask

  initial begin
    idle_inputs();
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    step();
    HRESET = 1'b0;

    // pass-through
    nonseq(32'h2000_0010, 1'b1);
    HWRITEM = 1'b1;
    step();
    idle_inputs();
    step();

    // hold for three inactive cycles, master address moving underneath
    nonseq(32'h4000_0000, 1'b0);
    HAUSERM = 32'hA5A5_0001; HBURSTM = 3'd3; HMASTLOCKM = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      HADDRM = $urandom; HAUSERM = $urandom; HREADYM = 1'b0; HTRANSM = 2'b11;
      resp_dec = 2'b01; active_dec = 1'b0;
      step();
    end
    active_dec = 1'b1; readyout_dec = 1'b1;
    step();
    idle_inputs();
    step();

    // release delayed by target wait states
    nonseq(32'h5000_0100, 1'b0);
    step();
    HREADYM = 1'b0; active_dec = 1'b1; readyout_dec = 1'b0;
    step();
    step();
    readyout_dec = 1'b1;
    step();
    idle_inputs();
    step();

    // IDLE and BUSY never load
    HSELM = 1'b1; HADDRM = 32'h6000_0000; active_dec = 1'b0;
    HTRANSM = 2'b00;
    step();
    HTRANSM = 2'b01;
    step();
    idle_inputs();
    step();

    // reset while holding drops the transfer
    nonseq(32'h7000_0040, 1'b0);
    step();
    active_dec = 1'b0; HREADYM = 1'b0;
    step();
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    check("h_addr_after_reset", dut.h_addr, 32'h0);
    idle_inputs();
    step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      HRESET       = ($urandom_range(0, 99) < 2);
      HSELM        = ($urandom_range(0, 9) < 8);
      HADDRM       = $urandom;
      HTRANSM      = 2'($urandom_range(0, 3));
      HWRITEM      = 1'($urandom);
      HSIZEM       = 3'($urandom);
      HBURSTM      = 3'($urandom);
      HPROTM       = 4'($urandom);
      HMASTLOCKM   = 1'($urandom);
      HAUSERM      = $urandom;
      HREADYM      = (held.size() != 0) ? ($urandom_range(0, 9) < 2)
                                        : ($urandom_range(0, 9) < 8);
      active_dec   = ($urandom_range(0, 9) < 6);
      readyout_dec = ($urandom_range(0, 9) < 7);
      resp_dec     = 2'($urandom_range(0, 1));
      step();
    end
    HRESET = 1'b0;
    idle_inputs();
    step();

    @(negedge HCLK);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l1_ahb_mtx_in_stage.md
# l1_ahb_mtx_in_stage

Slave-side input stage of the L1 AHB bus matrix, one instance per master port, sitting directly upstream of that port's address decoder. It passes the master's address phase to the decoder combinationally. If the decoder reports that the target output stage is not ready (`active_dec` low), it captures the address/control into a holding register and stalls the master until the output stage accepts the held transfer. It also returns the decoder's data-phase response to the master.

## Interface
Parameters:
- `DEC_LSB`, default 10: LSB of the address slice forwarded as `decode_addr_dec`.

Ports (all signals are synchronous to `HCLK`):
- `HCLK`  in  1  AHB system clock.
- `HRESET`  in  1  synchronous, active-high reset.
- `HSELM`  in  1  master-side HSEL.
- `HADDRM`  in  32  master HADDR.
- `HTRANSM`  in  2  master HTRANS.
- `HWRITEM`  in  1  master HWRITE.
- `HSIZEM`  in  3  master HSIZE.
- `HBURSTM`  in  3  master HBURST.
- `HPROTM`  in  4  master HPROT.
- `HMASTLOCKM`  in  1  master HMASTLOCK.
- `HAUSERM`  in  32  master address user bits (used only with the macro).
- `HREADYM`  in  1  bus HREADY seen by the master.
- `HREADYOUTM`  out  1  HREADYOUT returned to the master.
- `HRESPM`  out  2  HRESP returned to the master.
- `sel_dec`  out  1  HSEL to the decoder.
- `addr_dec`  out  32  full address to the output stages.
- `decode_addr_dec`  out  32-DEC_LSB  address `[31:DEC_LSB]` to the decoder.
- `trans_dec`, `write_dec`, `size_dec`, `burst_dec`, `prot_dec`, `lock_dec`, `auser_dec`  out  2/1/3/3/4/1/32  control signals to the decoder and output stages.
- `hready_dec`  out  1  HREADY to the decoder (the decoder's `HREADYS`).
- `active_dec`  in  1  decoder's combinational active signal for the presented address.
- `readyout_dec`  in  1  decoder's HREADYOUTS.
- `resp_dec`  in  2  decoder's HRESPS.

## Operation
- State is a single flag `pend` plus the holding registers `h_addr`, `h_trans`, `h_write`, `h_size`, `h_burst`, `h_prot`, `h_lock`, `h_auser`.
- `live_valid = HSELM & HTRANSM[1] & HREADYM` (NONSEQ or SEQ accepted on the bus).
- **Pass-through (`pend=0`):**
  - Outputs follow the master inputs.
  - `sel_dec = HSELM`.
  - `trans_dec = HSELM ? HTRANSM : 2'b00`.
  - `hready_dec = HREADYM`.
- **Held (`pend=1`):**
  - Outputs come from the holding registers.
  - `sel_dec = 1`, `trans_dec = h_trans`.
  - `hready_dec = readyout_dec`.
- **Load:** when `pend=0 & live_valid & ~active_dec`:
  - On the next edge, capture all master address/control into the holding registers.
  - Set `pend`.
- **Release:** when `pend=1 & active_dec & readyout_dec`, clear `pend` on the next edge. The held address phase completes in that cycle.
- **No re-load:** load is not possible while `pend=1`. The master is stalled, so no new address phase is accepted.
- **Response to master:**
  - `HREADYOUTM = pend ? 1'b0 : readyout_dec`.
  - `HRESPM = pend ? 2'b00 : resp_dec`.
- **Error:** an ERROR on the previous data phase while `pend=1` is returned only after release. The held transfer is still issued, as AHB-Lite permits continuing after ERROR.
- IDLE and BUSY transfers never load.

## Timing
- **Reset values:**
  - `pend=0`; all holding registers 0.
  - `HREADYOUTM` follows `readyout_dec`; `HRESPM` follows `resp_dec`.
- **Latency:**
  - Zero added cycles when `active_dec=1`: a pure combinational path.
  - A held transfer adds N+1 cycles. N counts the cycles with `active_dec` low or `readyout_dec` low after load.
- **Reset during `pend=1`:** `pend` clears on that edge and the held transfer is dropped. No output is asserted by the stage on the following cycle.
- **Simultaneous conditions:**
  - Load and release cannot coincide, because they are mutually exclusive on `pend`.
  - `active_dec` rising in the load cycle: no load occurs if it is high in that cycle.

## Configuration
- Macro: `L1AHBMTX_IN_STAGE_AUSER_EN`.
- **Defined:**
  - `h_auser` exists and is loaded with the other fields.
  - `auser_dec` equals `HAUSERM` when `pend=0`, and `h_auser` when `pend=1`.
- **Undefined:**
  - No `h_auser` register.
  - `auser_dec = 32'h0`.
  - `HAUSERM` is ignored.

## Test plan
- **Pass-through:** HADDRM=0x2000_0010, NONSEQ, `active_dec=1`, `readyout_dec=1`.
  - Required: `addr_dec=0x2000_0010` in the same cycle.
  - Required: `pend` stays 0 and `HREADYOUTM=1`.
- **Hold:** NONSEQ to 0x4000_0000 with `active_dec=0` for 3 cycles.
  - Required: `pend=1` from the next cycle.
  - Required: `addr_dec` stays 0x4000_0000 while HADDRM changes.
  - Required: `HREADYOUTM=0` for 4 cycles, and `pend` clears after `active_dec=1 & readyout_dec=1`.
- **Wait-state release:** held transfer with `active_dec=1` but `readyout_dec=0` for 2 cycles.
  - Required: `hready_dec=0` for those 2 cycles, then release.
- **IDLE/BUSY:** IDLE and BUSY with `active_dec=0`.
  - Required: no load, `pend=0`, `trans_dec` equals the input.
- **Reset mid-hold:** assert HRESET while `pend=1`.
  - Required: `pend=0` and `h_addr=0` after the edge.
- **Macro:** with the macro defined, HAUSERM=0xA5A5_0001 through a hold, then change HAUSERM.
  - Required: `auser_dec=0xA5A5_0001` held.
  - Without the macro: `auser_dec=0` throughout.
